// File: rtl/regfile_write_arbiter_pkg.sv
// rtl/regfile_write_arbiter_pkg.sv - shared constants and types for the register-bank write arbiter
// Purpose: bank geometry defaults, controller state encoding and requester ids.
// Ports: none (package).
package regfile_pkg;

  localparam int DATA_W   = 64;
  localparam int ADDR_W   = 5;
  localparam int NUM_REGS = 32;

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  typedef enum logic {REQ_A, REQ_B} req_id_t;

endpackage

// File: rtl/regfile_write_arbiter_if.sv
// rtl/regfile_write_arbiter_if.sv - valid/ready write-request channel into the bank write arbiter
// Purpose: one requester's write channel.
// Ports (signals):
//   valid - requester has a write pending
//   ready - arbiter accepts the write this cycle
//   addr  - destination register
//   data  - write data
// Modports: master (requester side), slave (arbiter side).
interface regfile_write_arbiter_if import regfile_pkg::*; #(
  parameter int DATA_W = regfile_pkg::DATA_W,
  parameter int ADDR_W = regfile_pkg::ADDR_W
);

  logic              valid;
  logic              ready;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] data;

  modport master (output valid, output addr, output data, input ready);
  modport slave  (input valid, input addr, input data, output ready);

endinterface

// File: rtl/regfile_write_arbiter_rr_arbiter2.sv
// rtl/regfile_write_arbiter_rr_arbiter2.sv - two-way round-robin arbiter with a single priority flop
// Purpose: offers the write port to requester A or B; priority moves to the loser after each grant.
// Ports:
//   clk, rst_n     - clock, synchronous active-low reset
//   req_a, req_b   - request lines
//   en             - arbitration enabled (controller in run state)
//   accept         - a grant was taken this cycle
//   gnt_a, gnt_b   - grant offered to A / B (independent of the requester's own valid)
module rr_arbiter2 import regfile_pkg::*; (
  input  logic clk,
  input  logic rst_n,
  input  logic req_a,
  input  logic req_b,
  input  logic en,
  input  logic accept,
  output logic gnt_a,
  output logic gnt_b
);

  req_id_t pri;

  // A grant is offered when the other side is idle or we hold priority, so
  // a requester can see ready before raising valid.
  assign gnt_a = en & (~req_b | (pri == REQ_A));
  assign gnt_b = en & (~req_a | (pri == REQ_B));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pri <= REQ_A;
    end else if (accept) begin
      pri <= (gnt_a & req_a) ? REQ_B : REQ_A;
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// rtl/regfile_write_arbiter.sv - owner of the register bank write port: init sweep then A/B arbitration
// Purpose: after reset writes INIT_VALUE into registers 0..NUM_REGS-1, one per cycle, then
//   shares the write port between requesters A and B with round-robin arbitration.
// Optional feature: REGFILE_ARB_BYPASS_EN forwards the in-flight write onto read data.
// Ports:
//   clk, rst_n              - clock, synchronous active-low reset
//   a, b                    - requester write channels (slave modport)
//   rf_write                - bank write enable (registered)
//   rf_address3             - bank write address (registered)
//   rf_input_data           - bank write data (registered)
//   busy                    - init sweep in progress
//   rd_addr1, rd_addr2      - read addresses (also go to the bank)
//   rf_data1, rf_data2      - raw bank read data
//   rd_data1, rd_data2      - read data to the datapath
module regfile_write_arbiter import regfile_pkg::*; #(
  parameter int                   DATA_W     = regfile_pkg::DATA_W,
  parameter int                   ADDR_W     = regfile_pkg::ADDR_W,
  parameter int                   NUM_REGS   = regfile_pkg::NUM_REGS,
  parameter logic [DATA_W-1:0]    INIT_VALUE = '0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  regfile_write_arbiter_if.slave  a,
  regfile_write_arbiter_if.slave  b,
  output logic                    rf_write,
  output logic [ADDR_W-1:0]       rf_address3,
  output logic [DATA_W-1:0]       rf_input_data,
  output logic                    busy,
  input  logic [ADDR_W-1:0]       rd_addr1,
  input  logic [ADDR_W-1:0]       rd_addr2,
  input  logic [DATA_W-1:0]       rf_data1,
  input  logic [DATA_W-1:0]       rf_data2,
  output logic [DATA_W-1:0]       rd_data1,
  output logic [DATA_W-1:0]       rd_data2
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_REGS - 1);

  state_t            state;
  logic [ADDR_W-1:0] cnt;
  logic              gnt_a;
  logic              gnt_b;
  logic              take_a;
  logic              take_b;
  logic              accept;

  rr_arbiter2 u_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .req_a  (a.valid),
    .req_b  (b.valid),
    .en     (state == ST_RUN),
    .accept (accept),
    .gnt_a  (gnt_a),
    .gnt_b  (gnt_b)
  );

  assign a.ready = gnt_a;
  assign b.ready = gnt_b;
  assign take_a  = a.valid & gnt_a;
  assign take_b  = b.valid & gnt_b;
  assign accept  = take_a | take_b;
  assign busy    = (state == ST_INIT);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= ST_INIT;
      cnt           <= '0;
      rf_write      <= 1'b0;
      rf_address3   <= '0;
      rf_input_data <= '0;
    end else begin
      case (state)
        ST_INIT: begin
          rf_write      <= 1'b1;
          rf_address3   <= cnt;
          rf_input_data <= INIT_VALUE;
          // The edge that issues the last register also enters run.
          if (cnt == LAST) begin
            state <= ST_RUN;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_RUN: begin
          rf_write <= accept;
          // Address/data hold when idle so the bank sees stable inputs.
          if (accept) begin
            rf_address3   <= take_a ? a.addr : b.addr;
            rf_input_data <= take_a ? a.data : b.data;
          end
        end
        default: state <= ST_INIT;
      endcase
    end
  end

`ifdef REGFILE_ARB_BYPASS_EN
  // The bank commits on the next edge; forward the pending write so a
  // same-cycle read sees the new value.
  assign rd_data1 = (rf_write && (rd_addr1 == rf_address3)) ? rf_input_data : rf_data1;
  assign rd_data2 = (rf_write && (rd_addr2 == rf_address3)) ? rf_input_data : rf_data2;
`else
  assign rd_data1 = rf_data1;
  assign rd_data2 = rf_data2;
  wire unused_rd_addr = &{1'b0, rd_addr1, rd_addr2};
`endif

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb/tb_regfile_write_arbiter.sv - scoreboard bench for the register-bank write arbiter
module tb_regfile_write_arbiter;
  import regfile_pkg::*;

  localparam int DW = 64;
  localparam int AW = 5;
  localparam int NR = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          rf_write;
  logic [AW-1:0] rf_address3;
  logic [DW-1:0] rf_input_data;
  logic          busy;
  logic [AW-1:0] rd_addr1 = '0;
  logic [AW-1:0] rd_addr2 = '0;
  logic [DW-1:0] rf_data1 = '0;
  logic [DW-1:0] rf_data2 = '0;
  logic [DW-1:0] rd_data1;
  logic [DW-1:0] rd_data2;

  regfile_write_arbiter_if #(.DATA_W(DW), .ADDR_W(AW)) a_if ();
  regfile_write_arbiter_if #(.DATA_W(DW), .ADDR_W(AW)) b_if ();

  regfile_write_arbiter dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .a             (a_if),
    .b             (b_if),
    .rf_write      (rf_write),
    .rf_address3   (rf_address3),
    .rf_input_data (rf_input_data),
    .busy          (busy),
    .rd_addr1      (rd_addr1),
    .rd_addr2      (rd_addr2),
    .rf_data1      (rf_data1),
    .rf_data2      (rf_data2),
    .rd_data1      (rd_data1),
    .rd_data2      (rd_data2)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            due;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  cyc = 0;
  int  checks = 0;
  int  failures = 0;
  bit  mon_en = 1'b0;
  bit  rnd_rd = 1'b0;
  bit  prev_rst = 1'b1;
  bit  pri_b = 1'b0;
  int  init_done = 1 << 30;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h cyc=%0d", name, act, exp, cyc);
    end
  endtask

  // Monitor: compares bank-side outputs and read data against the queue of
  // writes the model predicted for this cycle.
  always @(negedge clk) begin : monitor
    bit            cur;
    logic [DW-1:0] e1;
    logic [DW-1:0] e2;
    if (mon_en) begin
      cur = (exp_q.size() > 0) && (exp_q[0].due == cyc);
      e1  = rf_data1;
      e2  = rf_data2;
`ifdef REGFILE_ARB_BYPASS_EN
      if (cur && rd_addr1 == exp_q[0].addr) e1 = exp_q[0].data;
      if (cur && rd_addr2 == exp_q[0].addr) e2 = exp_q[0].data;
`endif
      chk("rd_data1", rd_data1, e1);
      chk("rd_data2", rd_data2, e2);
      if (cur) begin
        chk("rf_write", {63'd0, rf_write}, 64'd1);
        chk("rf_address3", {59'd0, rf_address3}, {59'd0, exp_q[0].addr});
        chk("rf_input_data", rf_input_data, exp_q[0].data);
        void'(exp_q.pop_front());
      end else begin
        chk("rf_write_idle", {63'd0, rf_write}, 64'd0);
        if (exp_q.size() > 0 && exp_q[0].due < cyc) begin
          chk("write_due_cycle", 64'(cyc), 64'(exp_q[0].due));
          void'(exp_q.pop_front());
        end
      end
    end
  end

  // One cycle of stimulus plus the reference model of the handshake.
  task automatic step(input bit rv,
                      input bit av, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                      input bit bv, input logic [AW-1:0] ba, input logic [DW-1:0] bd,
                      output bit acc_a, output bit acc_b);
    bit run;
    bit era;
    bit erb;
    @(negedge clk);
    #1;
    rst_n      = rv;
    a_if.valid = av;
    a_if.addr  = aa;
    a_if.data  = ad;
    b_if.valid = bv;
    b_if.addr  = ba;
    b_if.data  = bd;
    if (rnd_rd) begin
      rd_addr1 = AW'($urandom_range(0, 15));
      rd_addr2 = AW'($urandom_range(0, 15));
      rf_data1 = {$urandom, $urandom};
      rf_data2 = {$urandom, $urandom};
    end
    acc_a = 1'b0;
    acc_b = 1'b0;
    if (!rv) begin
      exp_q.delete();
      prev_rst  = 1'b1;
      init_done = 1 << 30;
    end else begin
      if (prev_rst) begin
        prev_rst = 1'b0;
        for (int i = 0; i < NR; i++) exp_q.push_back('{cyc + 1 + i, AW'(i), 64'd0});
        init_done = cyc + NR;
        pri_b     = 1'b0;
      end
      #1;
      run = (cyc >= init_done);
      era = run && (!bv || !pri_b);
      erb = run && (!av || pri_b);
      chk("busy", {63'd0, busy}, {63'd0, !run});
      chk("a_ready", {63'd0, a_if.ready}, {63'd0, era});
      chk("b_ready", {63'd0, b_if.ready}, {63'd0, erb});
      acc_a = av && era;
      acc_b = bv && erb;
      if (acc_a) begin
        exp_q.push_back('{cyc + 1, aa, ad});
        pri_b = 1'b1;
      end else if (acc_b) begin
        exp_q.push_back('{cyc + 1, ba, bd});
        pri_b = 1'b0;
      end
    end
  endtask

  task automatic idle(input int n);
    bit x;
    bit y;
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, '0, '0, 1'b0, '0, '0, x, y);
  endtask

  task automatic do_reset_init();
    bit x;
    bit y;
    step(1'b0, 1'b0, '0, '0, 1'b0, '0, '0, x, y);
    idle(NR + 1);
  endtask

  initial begin
    bit            ga;
    bit            gb;
    bit            pa;
    bit            pb;
    int            n;
    int            first;
    logic [AW-1:0] aa;
    logic [AW-1:0] ba;
    logic [DW-1:0] ad;
    logic [DW-1:0] bd;
    logic [AW-1:0] al[2];
    logic [AW-1:0] bl[2];
    int            ia;
    int            ib;

    a_if.valid = 1'b0; a_if.addr = '0; a_if.data = '0;
    b_if.valid = 1'b0; b_if.addr = '0; b_if.data = '0;

    // Reset state
    step(1'b0, 1'b0, '0, '0, 1'b0, '0, '0, ga, gb);
    mon_en = 1'b1;
    step(1'b0, 1'b0, '0, '0, 1'b0, '0, '0, ga, gb);
    chk("rst_busy", {63'd0, busy}, 64'd1);
    chk("rst_rf_write", {63'd0, rf_write}, 64'd0);
    chk("rst_rf_address3", {59'd0, rf_address3}, 64'd0);
    chk("rst_rf_input_data", rf_input_data, 64'd0);
    chk("rst_a_ready", {63'd0, a_if.ready}, 64'd0);
    chk("rst_b_ready", {63'd0, b_if.ready}, 64'd0);

    // Init sweep with no requests
    idle(NR + 1);

    // Contention right after init: A 1/2, B 3/4 -> A,B,A,B
    al[0] = 5'd1; al[1] = 5'd2; bl[0] = 5'd3; bl[1] = 5'd4;
    ia = 0; ib = 0; n = 0; first = -1;
    while ((ia < 2 || ib < 2) && n < 10) begin
      step(1'b1, ia < 2, al[ia % 2], 64'hA0 + 64'(ia), ib < 2, bl[ib % 2], 64'hB0 + 64'(ib), ga, gb);
      if (first < 0) first = ga ? 0 : (gb ? 1 : -1);
      if (ga) ia++;
      if (gb) ib++;
      n++;
    end
    chk("contend_cycles", 64'(n), 64'd4);
    chk("contend_first_is_a", 64'(first), 64'd0);
    idle(2);

    // A alone: addr 5, 0xDEAD_BEEF
    n = 0; ga = 1'b0;
    while (!ga && n < 10) begin
      step(1'b1, 1'b1, 5'd5, 64'hDEAD_BEEF, 1'b0, '0, '0, ga, gb);
      n++;
    end
    chk("a_alone_accept_cycles", 64'(n), 64'd1);
    idle(3);

    // Requests raised during init: no ready until after E32, A wins first
    step(1'b0, 1'b0, '0, '0, 1'b0, '0, '0, ga, gb);
    pa = 1'b1; pb = 1'b1; n = 0; first = -1;
    while ((pa || pb) && n < NR + 10) begin
      step(1'b1, pa, 5'd10, 64'h1111, pb, 5'd11, 64'h2222, ga, gb);
      if (first < 0 && (ga || gb)) first = ga ? 0 : 1;
      if (ga) pa = 1'b0;
      if (gb) pb = 1'b0;
      n++;
    end
    chk("init_req_first_is_a", 64'(first), 64'd0);
    chk("init_req_cycles", 64'(n), 64'(NR + 2));
    idle(2);

    // Reset while rf_write=1: the addr-7 request under reset is never issued
    step(1'b1, 1'b1, 5'd3, 64'h3333, 1'b0, '0, '0, ga, gb);
    chk("pre_reset_accept", {63'd0, ga}, 64'd1);
    step(1'b0, 1'b1, 5'd7, 64'h7777, 1'b0, '0, '0, ga, gb);
    idle(NR + 2);

    // Bypass on addr 9
    rd_addr1 = 5'd9; rf_data1 = 64'h55;
    step(1'b1, 1'b1, 5'd9, 64'h1234, 1'b0, '0, '0, ga, gb);
    chk("byp_accept", {63'd0, ga}, 64'd1);
    @(posedge clk); #1;
`ifdef REGFILE_ARB_BYPASS_EN
    chk("byp_rd_data1_write", rd_data1, 64'h1234);
`else
    chk("byp_rd_data1_write", rd_data1, 64'h55);
`endif
    idle(1);
    @(posedge clk); #1;
    chk("byp_rd_data1_after", rd_data1, 64'h55);
    idle(1);

    // Randomised traffic with hold-until-accepted requesters
    rnd_rd = 1'b1;
    pa = 1'b0; pb = 1'b0; aa = '0; ba = '0; ad = '0; bd = '0;
    for (int i = 0; i < 500; i++) begin
      if (!pa && $urandom_range(0, 2) != 0) begin
        pa = 1'b1; aa = AW'($urandom_range(0, 31)); ad = {$urandom, $urandom};
      end
      if (!pb && $urandom_range(0, 2) != 0) begin
        pb = 1'b1; ba = AW'($urandom_range(0, 31)); bd = {$urandom, $urandom};
      end
      step(1'b1, pa, aa, ad, pb, ba, bd, ga, gb);
      if (ga) pa = 1'b0;
      if (gb) pb = 1'b0;
    end
    idle(3);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
